cdc_sync_edge_filter: RTL and testbench



---
 rtl/cdc_pkg.sv | 27 ++
 rtl/cdc_sync_edge_filter_if.sv | 42 ++++
 rtl/cdc_glitch_filter.sv | 61 ++++++
 rtl/cdc_sync_edge_filter.sv | 91 +++++++++
 tb/tb_cdc_sync_edge_filter.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/cdc_pkg.sv
// ----------------------------------------------------------------------------
// cdc_pkg
// Shared constants and helpers for the CDC block family.
//   CDC_WIDTH / CDC_FILT_LEN / CDC_CNT_W : default block parameters
//   popcount()                           : number of set bits in a vector of
//                                          up to POP_MAX_W bits
// ----------------------------------------------------------------------------
package cdc_pkg;

    localparam int unsigned CDC_WIDTH    = 8;
    localparam int unsigned CDC_FILT_LEN = 3;
    localparam int unsigned CDC_CNT_W    = 8;

    // Widest vector popcount() accepts. Callers zero-extend narrower vectors.
    localparam int unsigned POP_MAX_W = 64;
    localparam int unsigned POP_CNT_W = $clog2(POP_MAX_W + 1);

    function automatic logic [POP_CNT_W-1:0] popcount(input logic [POP_MAX_W-1:0] vec);
        logic [POP_CNT_W-1:0] total;
        total = '0;
        for (int unsigned i = 0; i < POP_MAX_W; i++) begin
            total = total + POP_CNT_W'(vec[i]);
        end
        return total;
    endfunction

endpackage

// File: rtl/cdc_sync_edge_filter_if.sv
// ----------------------------------------------------------------------------
// cdc_sync_edge_filter_if
// Signal bundle between the edge filter and its consumer.
//   sync_in     : synchronized bits from the 2-flop synchronizer
//   evt_ack     : write-1-clear for evt_pending
//   cnt_clr     : synchronous clear of evt_count / cnt_sat
//   level_out   : filtered level
//   rise_pulse  : one-cycle pulse on filtered 0->1
//   fall_pulse  : one-cycle pulse on filtered 1->0
//   evt_pending : sticky per-bit edge flags
//   evt_count   : saturating total of filtered edges
//   cnt_sat     : sticky saturation flag
// master = consumer side, slave = the filter block.
// ----------------------------------------------------------------------------
interface cdc_sync_edge_filter_if
    import cdc_pkg::*;
#(
    parameter int unsigned WIDTH = CDC_WIDTH,
    parameter int unsigned CNT_W = CDC_CNT_W
) ();

    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] evt_ack;
    logic             cnt_clr;
    logic [WIDTH-1:0] level_out;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic [WIDTH-1:0] evt_pending;
    logic [CNT_W-1:0] evt_count;
    logic             cnt_sat;

    modport master (
        output sync_in, evt_ack, cnt_clr,
        input  level_out, rise_pulse, fall_pulse, evt_pending, evt_count, cnt_sat
    );

    modport slave (
        input  sync_in, evt_ack, cnt_clr,
        output level_out, rise_pulse, fall_pulse, evt_pending, evt_count, cnt_sat
    );

endinterface

// File: rtl/cdc_glitch_filter.sv
// ----------------------------------------------------------------------------
// cdc_glitch_filter
// One-bit glitch filter. A new level is accepted only after FILT_LEN
// consecutive samples that differ from the current filtered level.
//   slow_clk  : clock
//   reset_n   : asynchronous active-low reset
//   sample    : synchronized input bit
//   level     : filtered level (registered)
//   rise      : one-cycle pulse on filtered 0->1 (registered)
//   fall      : one-cycle pulse on filtered 1->0 (registered)
//   edge_next : combinational; level flips on the coming edge
// ----------------------------------------------------------------------------
module cdc_glitch_filter
    import cdc_pkg::*;
#(
    parameter int unsigned FILT_LEN = CDC_FILT_LEN
) (
    input  logic slow_clk,
    input  logic reset_n,
    input  logic sample,
    output logic level,
    output logic rise,
    output logic fall,
    output logic edge_next
);

    localparam int unsigned RUN_W = $clog2(FILT_LEN + 1);

    logic [RUN_W-1:0] run_cnt;
    logic             differs;

    // The FILT_LEN-th differing sample is the one taken while the counter
    // already holds FILT_LEN-1; with FILT_LEN=1 every differing sample flips.
    always_comb begin
        differs   = sample ^ level;
        edge_next = differs && (run_cnt == RUN_W'(FILT_LEN - 1));
    end

    always_ff @(posedge slow_clk or negedge reset_n) begin
        if (!reset_n) begin
            run_cnt <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else if (!differs) begin
            run_cnt <= '0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else if (edge_next) begin
            run_cnt <= '0;
            level   <= ~level;
            rise    <= ~level;
            fall    <= level;
        end else begin
            run_cnt <= run_cnt + 1'b1;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end
    end

endmodule

// File: rtl/cdc_sync_edge_filter.sv
// ----------------------------------------------------------------------------
// cdc_sync_edge_filter
// Slow-domain consumer of a multi-bit synchronizer: per-bit glitch filter,
// rise/fall pulses, sticky per-bit event flags and a saturating edge counter.
//   slow_clk : sole clock
//   reset_n  : asynchronous active-low reset
//   sif      : slave side of cdc_sync_edge_filter_if (inputs sync_in,
//              evt_ack, cnt_clr; outputs level_out, rise_pulse, fall_pulse,
//              evt_pending, evt_count, cnt_sat)
// WIDTH must not exceed cdc_pkg::POP_MAX_W.
// ----------------------------------------------------------------------------
module cdc_sync_edge_filter
    import cdc_pkg::*;
#(
    parameter int unsigned WIDTH    = CDC_WIDTH,
    parameter int unsigned FILT_LEN = CDC_FILT_LEN,
    parameter int unsigned CNT_W    = CDC_CNT_W
) (
    input logic                    slow_clk,
    input logic                    reset_n,
    cdc_sync_edge_filter_if.slave  sif
);

    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    logic [WIDTH-1:0]     level_vec;
    logic [WIDTH-1:0]     rise_vec;
    logic [WIDTH-1:0]     fall_vec;
    logic [WIDTH-1:0]     edge_vec;
    logic [WIDTH-1:0]     rise_next;
    logic [WIDTH-1:0]     fall_next;
    logic [WIDTH-1:0]     pending_q;
    logic [WIDTH-1:0]     pending_next;
    logic [POP_CNT_W-1:0] edge_pop;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_base;
    logic [CNT_W:0]       count_sum;
    logic [CNT_W-1:0]     count_next;
    logic                 sat_q;
    logic                 sat_hit;
    logic                 sat_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_filt
        cdc_glitch_filter #(
            .FILT_LEN (FILT_LEN)
        ) u_filt (
            .slow_clk  (slow_clk),
            .reset_n   (reset_n),
            .sample    (sif.sync_in[i]),
            .level     (level_vec[i]),
            .rise      (rise_vec[i]),
            .fall      (fall_vec[i]),
            .edge_next (edge_vec[i])
        );
    end

    always_comb begin
        rise_next    = edge_vec & ~level_vec;
        fall_next    = edge_vec & level_vec;
        // A new edge wins over a same-cycle acknowledge.
        pending_next = (pending_q & ~sif.evt_ack) | rise_next | fall_next;

        // Clear happens before this cycle's edges are added.
        edge_pop   = popcount(POP_MAX_W'(edge_vec));
        count_base = sif.cnt_clr ? '0 : count_q;
        count_sum  = {1'b0, count_base} + (CNT_W + 1)'(edge_pop);
        sat_hit    = (count_sum >= CNT_MAX);
        count_next = sat_hit ? CNT_MAX[CNT_W-1:0] : count_sum[CNT_W-1:0];
        sat_next   = (sif.cnt_clr ? 1'b0 : sat_q) | sat_hit;
    end

    always_ff @(posedge slow_clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            count_q   <= '0;
            sat_q     <= 1'b0;
        end else begin
            pending_q <= pending_next;
            count_q   <= count_next;
            sat_q     <= sat_next;
        end
    end

    assign sif.level_out   = level_vec;
    assign sif.rise_pulse  = rise_vec;
    assign sif.fall_pulse  = fall_vec;
    assign sif.evt_pending = pending_q;
    assign sif.evt_count   = count_q;
    assign sif.cnt_sat     = sat_q;

endmodule

// File: tb/tb_cdc_sync_edge_filter.sv
// ----------------------------------------------------------------------------
// tb_cdc_sync_edge_filter
// Directed bench for cdc_sync_edge_filter: one instance with CNT_W=8 and one
// with CNT_W=4 for the saturation scenario, both FILT_LEN=3, WIDTH=8.
// ----------------------------------------------------------------------------
module tb_cdc_sync_edge_filter;

    logic slow_clk = 1'b0;
    logic reset_n  = 1'b1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 slow_clk = ~slow_clk;

    cdc_sync_edge_filter_if #(.WIDTH(8), .CNT_W(8)) bus8 ();
    cdc_sync_edge_filter_if #(.WIDTH(8), .CNT_W(4)) bus4 ();

    cdc_sync_edge_filter #(
        .WIDTH    (8),
        .FILT_LEN (3),
        .CNT_W    (8)
    ) dut8 (
        .slow_clk (slow_clk),
        .reset_n  (reset_n),
        .sif      (bus8)
    );

    cdc_sync_edge_filter #(
        .WIDTH    (8),
        .FILT_LEN (3),
        .CNT_W    (4)
    ) dut4 (
        .slow_clk (slow_clk),
        .reset_n  (reset_n),
        .sif      (bus4)
    );

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge slow_clk);
        #1;
    endtask

    task automatic test_reset();
        bus8.sync_in = 8'h00; bus8.evt_ack = 8'h00; bus8.cnt_clr = 1'b0;
        bus4.sync_in = 8'h00; bus4.evt_ack = 8'h00; bus4.cnt_clr = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (bus8.level_out !== 8'h00) begin errors++; $display("FAIL reset_level: got %h expected %h", bus8.level_out, 8'h00); end
        checks++; if (bus8.rise_pulse !== 8'h00 || bus8.fall_pulse !== 8'h00) begin errors++; $display("FAIL reset_pulses: got rise %h fall %h expected 00 00", bus8.rise_pulse, bus8.fall_pulse); end
        checks++; if (bus8.evt_pending !== 8'h00) begin errors++; $display("FAIL reset_pending: got %h expected %h", bus8.evt_pending, 8'h00); end
        checks++; if (bus8.evt_count !== 8'd0 || bus8.cnt_sat !== 1'b0) begin errors++; $display("FAIL reset_count: got %0d sat %b expected 0 sat 0", bus8.evt_count, bus8.cnt_sat); end
        checks++; if (bus4.evt_count !== 4'd0 || bus4.cnt_sat !== 1'b0 || bus4.level_out !== 8'h00) begin errors++; $display("FAIL reset_dut4: got count %0d sat %b level %h expected 0 0 00", bus4.evt_count, bus4.cnt_sat, bus4.level_out); end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        checks++; if (bus8.level_out !== 8'h00 || bus8.evt_count !== 8'd0) begin errors++; $display("FAIL post_reset_idle: got level %h count %0d expected 00 0", bus8.level_out, bus8.evt_count); end
    endtask

    task automatic test_single_rise();
        bus8.sync_in = 8'h01;
        tick();
        checks++; if (bus8.level_out !== 8'h00 || bus8.rise_pulse !== 8'h00) begin errors++; $display("FAIL rise_e1: got level %h rise %h expected 00 00", bus8.level_out, bus8.rise_pulse); end
        tick();
        checks++; if (bus8.level_out !== 8'h00 || bus8.evt_count !== 8'd0) begin errors++; $display("FAIL rise_e2: got level %h count %0d expected 00 0", bus8.level_out, bus8.evt_count); end
        tick();
        checks++; if (bus8.level_out !== 8'h01) begin errors++; $display("FAIL rise_e3_level: got %h expected %h", bus8.level_out, 8'h01); end
        checks++; if (bus8.rise_pulse !== 8'h01 || bus8.fall_pulse !== 8'h00) begin errors++; $display("FAIL rise_e3_pulse: got rise %h fall %h expected 01 00", bus8.rise_pulse, bus8.fall_pulse); end
        checks++; if (bus8.evt_pending !== 8'h01) begin errors++; $display("FAIL rise_e3_pending: got %h expected %h", bus8.evt_pending, 8'h01); end
        checks++; if (bus8.evt_count !== 8'd1) begin errors++; $display("FAIL rise_e3_count: got %0d expected %0d", bus8.evt_count, 1); end
        tick();
        checks++; if (bus8.rise_pulse !== 8'h00 || bus8.level_out !== 8'h01) begin errors++; $display("FAIL rise_e4: got rise %h level %h expected 00 01", bus8.rise_pulse, bus8.level_out); end
        tick();
        checks++; if (bus8.level_out !== 8'h01 || bus8.evt_count !== 8'd1) begin errors++; $display("FAIL rise_e5: got level %h count %0d expected 01 1", bus8.level_out, bus8.evt_count); end
    endtask

    task automatic test_glitch();
        bus8.sync_in = 8'h09;
        tick();
        tick();
        checks++; if (bus8.level_out !== 8'h01 || bus8.rise_pulse !== 8'h00) begin errors++; $display("FAIL glitch_hold: got level %h rise %h expected 01 00", bus8.level_out, bus8.rise_pulse); end
        bus8.sync_in = 8'h01;
        tick();
        checks++; if (bus8.level_out !== 8'h01 || bus8.rise_pulse !== 8'h00) begin errors++; $display("FAIL glitch_drop: got level %h rise %h expected 01 00", bus8.level_out, bus8.rise_pulse); end
        tick();
        tick();
        checks++; if (bus8.level_out !== 8'h01 || bus8.evt_count !== 8'd1 || bus8.evt_pending !== 8'h01) begin errors++; $display("FAIL glitch_after: got level %h count %0d pend %h expected 01 1 01", bus8.level_out, bus8.evt_count, bus8.evt_pending); end
    endtask

    task automatic test_all_bits();
        bus8.sync_in = 8'h00;
        tick(); tick(); tick();
        checks++; if (bus8.fall_pulse !== 8'h01 || bus8.level_out !== 8'h00 || bus8.evt_count !== 8'd2) begin errors++; $display("FAIL fall0: got fall %h level %h count %0d expected 01 00 2", bus8.fall_pulse, bus8.level_out, bus8.evt_count); end
        bus8.evt_ack = 8'h01;
        tick();
        bus8.evt_ack = 8'h00;
        checks++; if (bus8.evt_pending !== 8'h00) begin errors++; $display("FAIL ack_clear: got %h expected %h", bus8.evt_pending, 8'h00); end
        bus8.sync_in = 8'hFF;
        tick(); tick();
        checks++; if (bus8.level_out !== 8'h00) begin errors++; $display("FAIL ff_early: got %h expected %h", bus8.level_out, 8'h00); end
        tick();
        checks++; if (bus8.rise_pulse !== 8'hFF || bus8.fall_pulse !== 8'h00 || bus8.level_out !== 8'hFF) begin errors++; $display("FAIL ff_rise: got rise %h fall %h level %h expected FF 00 FF", bus8.rise_pulse, bus8.fall_pulse, bus8.level_out); end
        checks++; if (bus8.evt_count !== 8'd10 || bus8.evt_pending !== 8'hFF) begin errors++; $display("FAIL ff_count: got count %0d pend %h expected 10 FF", bus8.evt_count, bus8.evt_pending); end
        tick();
        checks++; if (bus8.rise_pulse !== 8'h00) begin errors++; $display("FAIL ff_rise_width: got %h expected %h", bus8.rise_pulse, 8'h00); end
        bus8.sync_in = 8'h00;
        tick(); tick(); tick();
        checks++; if (bus8.fall_pulse !== 8'hFF || bus8.rise_pulse !== 8'h00 || bus8.level_out !== 8'h00) begin errors++; $display("FAIL ff_fall: got fall %h rise %h level %h expected FF 00 00", bus8.fall_pulse, bus8.rise_pulse, bus8.level_out); end
        checks++; if (bus8.evt_count !== 8'd18) begin errors++; $display("FAIL ff_fall_count: got %0d expected %0d", bus8.evt_count, 18); end
        tick();
        checks++; if (bus8.fall_pulse !== 8'h00) begin errors++; $display("FAIL ff_fall_width: got %h expected %h", bus8.fall_pulse, 8'h00); end
    endtask

    task automatic test_ack_collision();
        bus8.evt_ack = 8'hFE;
        tick();
        bus8.evt_ack = 8'h00;
        checks++; if (bus8.evt_pending !== 8'h01) begin errors++; $display("FAIL ack_partial: got %h expected %h", bus8.evt_pending, 8'h01); end
        bus8.sync_in = 8'h01;
        tick(); tick();
        bus8.evt_ack = 8'h01;
        tick();
        checks++; if (bus8.rise_pulse !== 8'h01 || bus8.evt_pending !== 8'h01) begin errors++; $display("FAIL ack_collide: got rise %h pend %h expected 01 01", bus8.rise_pulse, bus8.evt_pending); end
        checks++; if (bus8.evt_count !== 8'd19) begin errors++; $display("FAIL ack_collide_count: got %0d expected %0d", bus8.evt_count, 19); end
        tick();
        bus8.evt_ack = 8'h00;
        checks++; if (bus8.evt_pending !== 8'h00 || bus8.rise_pulse !== 8'h00) begin errors++; $display("FAIL ack_alone: got pend %h rise %h expected 00 00", bus8.evt_pending, bus8.rise_pulse); end
    endtask

    task automatic test_toggle();
        for (int i = 0; i < 8; i++) begin
            bus8.sync_in = (i % 2 == 0) ? 8'h00 : 8'h01;
            tick();
            checks++; if (bus8.level_out !== 8'h01 || bus8.fall_pulse !== 8'h00) begin errors++; $display("FAIL toggle_%0d: got level %h fall %h expected 01 00", i, bus8.level_out, bus8.fall_pulse); end
        end
        checks++; if (bus8.evt_count !== 8'd19) begin errors++; $display("FAIL toggle_count: got %0d expected %0d", bus8.evt_count, 19); end
    endtask

    task automatic test_saturation();
        bus4.sync_in = 8'hFF;
        tick(); tick(); tick();
        checks++; if (bus4.evt_count !== 4'd8 || bus4.cnt_sat !== 1'b0) begin errors++; $display("FAIL sat_step8: got %0d sat %b expected 8 0", bus4.evt_count, bus4.cnt_sat); end
        bus4.sync_in = 8'h03;
        tick(); tick(); tick();
        checks++; if (bus4.evt_count !== 4'd14 || bus4.cnt_sat !== 1'b0 || bus4.fall_pulse !== 8'hFC) begin errors++; $display("FAIL sat_step14: got %0d sat %b fall %h expected 14 0 FC", bus4.evt_count, bus4.cnt_sat, bus4.fall_pulse); end
        bus4.sync_in = 8'hFC;
        tick(); tick(); tick();
        checks++; if (bus4.evt_count !== 4'd15 || bus4.cnt_sat !== 1'b1) begin errors++; $display("FAIL sat_clamp: got %0d sat %b expected 15 1", bus4.evt_count, bus4.cnt_sat); end
        checks++; if (bus4.rise_pulse !== 8'hFC || bus4.fall_pulse !== 8'h03) begin errors++; $display("FAIL sat_pulses: got rise %h fall %h expected FC 03", bus4.rise_pulse, bus4.fall_pulse); end
        tick();
        checks++; if (bus4.evt_count !== 4'd15 || bus4.cnt_sat !== 1'b1) begin errors++; $display("FAIL sat_sticky: got %0d sat %b expected 15 1", bus4.evt_count, bus4.cnt_sat); end
        bus4.sync_in = 8'hFF;
        tick(); tick();
        bus4.cnt_clr = 1'b1;
        tick();
        bus4.cnt_clr = 1'b0;
        checks++; if (bus4.evt_count !== 4'd2 || bus4.cnt_sat !== 1'b0) begin errors++; $display("FAIL clr_add: got %0d sat %b expected 2 0", bus4.evt_count, bus4.cnt_sat); end
        checks++; if (bus4.rise_pulse !== 8'h03) begin errors++; $display("FAIL clr_rise: got %h expected %h", bus4.rise_pulse, 8'h03); end
        checks++; if (bus8.evt_count !== 8'd19) begin errors++; $display("FAIL sat_isolation: got %0d expected %0d", bus8.evt_count, 19); end
    endtask

    task automatic test_midrun_reset();
        bus8.sync_in = 8'h03;
        tick(); tick();
        checks++; if (bus8.level_out !== 8'h01) begin errors++; $display("FAIL partial_run: got %h expected %h", bus8.level_out, 8'h01); end
        bus8.sync_in = 8'h02;
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (bus8.level_out !== 8'h00 || bus8.evt_count !== 8'd0 || bus8.evt_pending !== 8'h00) begin errors++; $display("FAIL async_reset: got level %h count %0d pend %h expected 00 0 00", bus8.level_out, bus8.evt_count, bus8.evt_pending); end
        checks++; if (bus4.evt_count !== 4'd0 || bus4.level_out !== 8'h00) begin errors++; $display("FAIL async_reset_dut4: got count %0d level %h expected 0 00", bus4.evt_count, bus4.level_out); end
        tick();
        reset_n = 1'b1;
        tick(); tick();
        checks++; if (bus8.level_out !== 8'h00 || bus8.rise_pulse !== 8'h00) begin errors++; $display("FAIL fresh_run_early: got level %h rise %h expected 00 00", bus8.level_out, bus8.rise_pulse); end
        tick();
        checks++; if (bus8.level_out !== 8'h02 || bus8.rise_pulse !== 8'h02) begin errors++; $display("FAIL fresh_run_flip: got level %h rise %h expected 02 02", bus8.level_out, bus8.rise_pulse); end
        checks++; if (bus8.evt_count !== 8'd1 || bus8.evt_pending !== 8'h02) begin errors++; $display("FAIL fresh_run_count: got count %0d pend %h expected 1 02", bus8.evt_count, bus8.evt_pending); end
    endtask

    initial begin
        test_reset();
        test_single_rise();
        test_glitch();
        test_all_bits();
        test_ack_collision();
        test_toggle();
        test_saturation();
        test_midrun_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
